lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter: RETRY_LIMIT, default 3, max bus reissues after rty_i before error response.
REQ-002 clk_i  input  1  system clock; all state changes on rising edge.
REQ-003 rst_ni  input  1  reset; asynchronous, active-low.
REQ-004 req_valid_i  input  1  execute stage presents a load/store.
REQ-005 req_ready_o  output  1  LSU can accept a request.
REQ-006 req_we_i  input  1  1 = store, 0 = load.
REQ-007 req_funct3_i  input  3  RV32I load/store funct3.
REQ-008 req_addr_i  input  32  effective byte address (rs1 + offset).
REQ-009 req_wdata_i  input  32  rs2 value for stores.
REQ-010 rsp_valid_o  output  1  one-cycle completion pulse.
REQ-011 rsp_rdata_o  output  32  extended load data; 0 for stores/errors.
REQ-012 rsp_err_o  output  1  access faulted; qualified by rsp_valid_o.
REQ-013 Wishbone master: cyc_o, stb_o, we_o (out, 1); adr_o (out, 32); sel_o (out, 4); dat_o (out, 32); dat_i (in, 32); ack_i, err_i, rty_i (in, 1).

Function
REQ-014 FSM states: IDLE, BUS, WAIT, RESP; req_ready_o = 1 only in IDLE.
REQ-015 IDLE: on req_valid_i, latch request; legal -> BUS next cycle; illegal funct3 (011, 110, 111; stores with funct3[2]=1) -> RESP with rsp_err_o=1, no bus cycle.
REQ-016 BUS: cyc_o=stb_o=1; adr_o = {addr[31:2], 2'b00}; we_o = latched req_we_i; all bus outputs stable until termination.
REQ-017 sel_o: byte = 4'b0001 << addr[1:0]; half = 4'b0011 << {addr[1],1'b0}; word = 4'b1111.
REQ-018 dat_o: byte = wdata[7:0] replicated x4; half = wdata[15:0] replicated x2; word = wdata.
REQ-019 ack_i sampled high in BUS -> capture dat_i, -> RESP; err_i -> RESP with error; err_i wins over ack_i and rty_i when simultaneous.
REQ-020 rty_i (no ack/err) -> WAIT: cyc_o=stb_o=0 for one cycle, retry counter +1, -> BUS; when counter already equals RETRY_LIMIT -> RESP with error.
REQ-021 Loads: select lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes 32 bits unchanged.
REQ-022 RESP: rsp_valid_o=1 for exactly one cycle, -> IDLE; min latency request-accept to rsp_valid_o = 3 cycles with zero-wait ack.
REQ-023 Back-to-back: new request accepted in the IDLE cycle following RESP.
REQ-024 rsp_rdata_o and rsp_err_o hold their value until the next rsp_valid_o.

Reset
REQ-025 rst_ni low: state IDLE, retry counter 0, cyc_o/stb_o/we_o/rsp_valid_o/rsp_err_o = 0, adr_o/sel_o/dat_o/rsp_rdata_o = 0, req_ready_o = 0 while reset asserted.
REQ-026 Reset mid-transaction drops cyc_o/stb_o immediately (asynchronously); no response is generated for the aborted request.

Configuration
REQ-027 Macro LSU_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 -> RESP with rsp_err_o=1, no bus cycle.
REQ-028 LSU_MISALIGN_TRAP_EN undefined: misaligned halves/words are issued with low address bits ignored (half uses addr[1], word uses lane 0), no error.

Verification
REQ-029 Memory word 0x8382_8180 at 0x2000_0000; LB addr 0x2000_0000 -> rsp_rdata_o 0xFFFF_FF80, sel_o 0001.
REQ-030 Same word; LHU addr 0x2000_0002 -> sel_o 1100, rsp_rdata_o 0x0000_8382; LH -> 0xFFFF_8382.
REQ-031 Word 0xDEAD_BEEF; SB wdata 0xF3F2_F1F0 addr 0x2000_0003 -> sel_o 1000, dat_o 0xF0F0_F0F0, memory 0xF0AD_BEEF, rsp_err_o 0.
REQ-032 Slave asserts rty_i 3 times then ack_i on LW -> 4 BUS phases separated by one idle cycle, correct data, no error; 4 rty_i -> rsp_err_o 1.
REQ-033 LW addr 0x2000_0002: with LSU_MISALIGN_TRAP_EN -> error response, cyc_o never asserted; without -> reads word at 0x2000_0000.
REQ-034 rst_ni low during BUS -> cyc_o falls same time step; after release, next LW completes normally with no stray rsp_valid_o.

Source files
------------

// File: rtl/lsu.sv
// ---------------------------------------------------------------------------
// lsu -- RV32I load/store unit with a single-transaction Wishbone master.
//
// A load or store from the execute stage is accepted in IDLE, issued on the
// bus in BUS, optionally retried through WAIT, and completed with a
// one-cycle pulse in RESP.
//
// Parameters
//   RETRY_LIMIT    bus reissues allowed after rty_i before an error response
//
// Configuration macro
//   LSU_MISALIGN_TRAP_EN  when defined, a misaligned half or word returns an
//                         error without a bus cycle. When undefined, the low
//                         address bits that do not fit the access size are
//                         ignored.
//
// Ports
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   req_valid_i/req_ready_o   request handshake (see below)
//   req_we_i, req_funct3_i    store flag, RV32I funct3
//   req_addr_i, req_wdata_i   effective byte address, store data
//   rsp_valid_o               one-cycle completion pulse
//   rsp_rdata_o, rsp_err_o    extended load data / fault; held until the
//                             next rsp_valid_o
//   cyc_o, stb_o, we_o, adr_o, sel_o, dat_o, dat_i, ack_i, err_i, rty_i
//                             Wishbone master port
//   state_o                   current FSM state for debug
//
// Handshake: a request transfers on a rising edge where req_valid_i and
// req_ready_o are both high. req_ready_o is high only in IDLE and only while
// reset is released. Exactly one rsp_valid_o pulse follows each accepted
// request, unless reset aborts the transaction.
// ---------------------------------------------------------------------------
module lsu #(
   parameter int RETRY_LIMIT = 3
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [2:0]  req_funct3_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o,
   output logic        cyc_o,
   output logic        stb_o,
   output logic        we_o,
   output logic [31:0] adr_o,
   output logic [3:0]  sel_o,
   output logic [31:0] dat_o,
   input  logic [31:0] dat_i,
   input  logic        ack_i,
   input  logic        err_i,
   input  logic        rty_i,
   output logic [1:0]  state_o
);

   localparam int CNT_W = (RETRY_LIMIT < 1) ? 1 : $clog2(RETRY_LIMIT + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t state_q, state_d;

   logic [2:0]       funct3_q;
   logic [1:0]       addr_lo_q;
   logic [CNT_W-1:0] retry_q;

   logic        accept;
   logic        ready_raw;
   logic        cnt_inc;
   logic        rsp_capture;
   logic        rsp_err_d;
   logic [31:0] rsp_rdata_d;

   logic        legal;
   logic        misaligned;
   logic [3:0]  sel_d;
   logic [31:0] dat_d;
   logic [31:0] load_data;
   logic [7:0]  lane_byte;
   logic [15:0] lane_half;

   // ---------------- request decode ----------------
   always_comb begin
      legal = 1'b0;
      case (req_funct3_i)
         3'b000, 3'b001, 3'b010: legal = 1'b1;
         3'b100, 3'b101:         legal = ~req_we_i;   // LBU/LHU have no store form
         default:                legal = 1'b0;
      endcase
   end

`ifdef LSU_MISALIGN_TRAP_EN
   assign misaligned = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                       ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
`else
   assign misaligned = 1'b0;
`endif

   // Size is funct3[1:0]; funct3[2] only selects zero extension for loads.
   // Without the trap, halves use addr[1] only and words always use lane 0.
   always_comb begin
      sel_d = 4'b1111;
      dat_d = req_wdata_i;
      case (req_funct3_i[1:0])
         2'b00: begin
            sel_d = 4'b0001 << req_addr_i[1:0];
            dat_d = {4{req_wdata_i[7:0]}};
         end
         2'b01: begin
            sel_d = 4'b0011 << {req_addr_i[1], 1'b0};
            dat_d = {2{req_wdata_i[15:0]}};
         end
         default: begin
            sel_d = 4'b1111;
            dat_d = req_wdata_i;
         end
      endcase
   end

   // ---------------- load lane extraction ----------------
   logic [31:0] byte_shift;
   logic [31:0] half_shift;
   assign byte_shift = dat_i >> {addr_lo_q, 3'b000};
   assign half_shift = dat_i >> {addr_lo_q[1], 4'b0000};
   assign lane_byte  = byte_shift[7:0];
   assign lane_half  = half_shift[15:0];

   always_comb begin
      load_data = dat_i;
      case (funct3_q)
         3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
         3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
         3'b100:  load_data = {24'h0, lane_byte};
         3'b101:  load_data = {16'h0, lane_half};
         default: load_data = dat_i;
      endcase
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      ready_raw   = 1'b0;
      cyc_o       = 1'b0;
      stb_o       = 1'b0;
      rsp_valid_o = 1'b0;
      accept      = 1'b0;
      cnt_inc     = 1'b0;
      rsp_capture = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = 32'h0;
      case (state_q)
         IDLE: begin
            ready_raw = 1'b1;
            if (req_valid_i) begin
               accept = 1'b1;
               if (legal && !misaligned) begin
                  state_d = BUS;
               end else begin
                  state_d     = RESP;
                  rsp_capture = 1'b1;
                  rsp_err_d   = 1'b1;
               end
            end
         end
         BUS: begin
            cyc_o = 1'b1;
            stb_o = 1'b1;
            // err_i has priority over ack_i and rty_i.
            if (err_i) begin
               state_d     = RESP;
               rsp_capture = 1'b1;
               rsp_err_d   = 1'b1;
            end else if (ack_i) begin
               state_d     = RESP;
               rsp_capture = 1'b1;
               rsp_rdata_d = we_o ? 32'h0 : load_data;
            end else if (rty_i) begin
               if (retry_q == CNT_W'(RETRY_LIMIT)) begin
                  state_d     = RESP;
                  rsp_capture = 1'b1;
                  rsp_err_d   = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_inc = 1'b1;
               end
            end
         end
         WAIT: begin
            state_d = BUS;
         end
         RESP: begin
            rsp_valid_o = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Reset holds the FSM in IDLE, so ready is also gated by rst_ni directly.
   assign req_ready_o = ready_raw & rst_ni;
   assign state_o     = state_q;

   // ---------------- datapath registers ----------------
   // Bus address/select/data are loaded once at accept and held through all
   // retries, so they stay stable until the cycle terminates.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         funct3_q    <= 3'b000;
         addr_lo_q   <= 2'b00;
         retry_q     <= '0;
         we_o        <= 1'b0;
         adr_o       <= 32'h0;
         sel_o       <= 4'b0000;
         dat_o       <= 32'h0;
         rsp_rdata_o <= 32'h0;
         rsp_err_o   <= 1'b0;
      end else begin
         if (accept) begin
            funct3_q  <= req_funct3_i;
            addr_lo_q <= req_addr_i[1:0];
            retry_q   <= '0;
            we_o      <= req_we_i;
            adr_o     <= {req_addr_i[31:2], 2'b00};
            sel_o     <= sel_d;
            dat_o     <= dat_d;
         end else if (cnt_inc) begin
            retry_q <= retry_q + 1'b1;
         end
         if (rsp_capture) begin
            rsp_rdata_o <= rsp_rdata_d;
            rsp_err_o   <= rsp_err_d;
         end
      end
   end

endmodule

// File: tb/tb_lsu.sv
// ---------------------------------------------------------------------------
// tb_lsu -- directed bench for lsu with a one-word-per-lane Wishbone slave
// model. The slave can inject a configurable number of rty_i responses, force
// err_i, or stall (no termination).
// ---------------------------------------------------------------------------
module tb_lsu;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_ni;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_we_i;
   logic [2:0]  req_funct3_i;
   logic [31:0] req_addr_i;
   logic [31:0] req_wdata_i;
   logic        rsp_valid_o;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic        cyc_o, stb_o, we_o;
   logic [31:0] adr_o;
   logic [3:0]  sel_o;
   logic [31:0] dat_o;
   logic [31:0] dat_i;
   logic        ack_i, err_i, rty_i;
   logic [1:0]  state_o;

   lsu #(.RETRY_LIMIT(3)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_we_i     (req_we_i),
      .req_funct3_i (req_funct3_i),
      .req_addr_i   (req_addr_i),
      .req_wdata_i  (req_wdata_i),
      .rsp_valid_o  (rsp_valid_o),
      .rsp_rdata_o  (rsp_rdata_o),
      .rsp_err_o    (rsp_err_o),
      .cyc_o        (cyc_o),
      .stb_o        (stb_o),
      .we_o         (we_o),
      .adr_o        (adr_o),
      .sel_o        (sel_o),
      .dat_o        (dat_o),
      .dat_i        (dat_i),
      .ack_i        (ack_i),
      .err_i        (err_i),
      .rty_i        (rty_i),
      .state_o      (state_o)
   );

   // ---------------- Wishbone slave model ----------------
   logic [31:0] mem [0:3];
   int          rty_cfg   = 0;
   logic        err_cfg   = 1'b0;
   logic        stall_cfg = 1'b0;
   int          rty_given;

   always_comb begin
      ack_i = 1'b0;
      err_i = 1'b0;
      rty_i = 1'b0;
      dat_i = mem[adr_o[3:2]];
      if (cyc_o && stb_o && !stall_cfg) begin
         err_i = err_cfg;
         if (rty_given < rty_cfg) rty_i = 1'b1;
         else                     ack_i = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         rty_given <= 0;
      end else begin
         if (ack_i || err_i || rsp_valid_o) rty_given <= 0;
         else if (rty_i)                    rty_given <= rty_given + 1;
         if (ack_i && !err_i && we_o) begin
            for (int b = 0; b < 4; b++)
               if (sel_o[b]) mem[adr_o[3:2]][8*b +: 8] <= dat_o[8*b +: 8];
         end
      end
   end

   // ---------------- bus monitor ----------------
   int          bus_cycles = 0;
   int          bus_starts = 0;
   int          rsp_count  = 0;
   int          unstable   = 0;
   logic        cyc_prev   = 1'b0;
   logic [31:0] prev_adr   = 32'h0;
   logic [31:0] last_adr   = 32'h0;
   logic [31:0] last_dat   = 32'h0;
   logic [3:0]  last_sel   = 4'h0;
   logic        last_we    = 1'b0;

   always @(posedge clk) begin
      cyc_prev <= cyc_o;
      prev_adr <= adr_o;
      if (cyc_o && stb_o) begin
         bus_cycles <= bus_cycles + 1;
         last_adr   <= adr_o;
         last_dat   <= dat_o;
         last_sel   <= sel_o;
         last_we    <= we_o;
      end
      if (cyc_o && !cyc_prev) bus_starts <= bus_starts + 1;
      if (cyc_o && cyc_prev && (adr_o !== prev_adr)) unstable <= unstable + 1;
      if (rsp_valid_o) rsp_count <= rsp_count + 1;
   end

   // ---------------- scoreboard counters / check ----------------
   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // ---------------- driver ----------------
   // Presents one request at a negedge, returns at the negedge of the
   // response cycle. lat counts cycles with the request-present cycle as 1.
   task automatic do_req(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output int wait_cyc);
      req_we_i     = we;
      req_funct3_i = f3;
      req_addr_i   = addr;
      req_wdata_i  = wdata;
      req_valid_i  = 1'b1;
      wait_cyc     = 0;
      while (!req_ready_o && wait_cyc < 50) begin
         @(negedge clk);
         wait_cyc++;
      end
      lat = 1;
      @(negedge clk);
      req_valid_i = 1'b0;
      lat = 2;
      while (!rsp_valid_o && lat < 60) begin
         @(negedge clk);
         lat++;
      end
   endtask

   // ---------------- directed sequence ----------------
   int lat, wt, bc0, bs0, rc0;

   initial begin
      rst_ni       = 1'b0;
      req_valid_i  = 1'b0;
      req_we_i     = 1'b0;
      req_funct3_i = 3'b000;
      req_addr_i   = 32'h0;
      req_wdata_i  = 32'h0;
      for (int i = 0; i < 4; i++) mem[i] = 32'h0;

      repeat (3) @(negedge clk);
      chk("rst_ready",  {31'h0, req_ready_o}, 32'h0);
      chk("rst_cyc",    {30'h0, cyc_o, stb_o}, 32'h0);
      chk("rst_we",     {31'h0, we_o}, 32'h0);
      chk("rst_rspv",   {30'h0, rsp_valid_o, rsp_err_o}, 32'h0);
      chk("rst_adr",    adr_o, 32'h0);
      chk("rst_sel",    {28'h0, sel_o}, 32'h0);
      chk("rst_dat",    dat_o, 32'h0);
      chk("rst_rdata",  rsp_rdata_o, 32'h0);
      chk("rst_state",  {30'h0, state_o}, 32'h0);
      rst_ni = 1'b1;
      @(negedge clk);
      chk("idle_ready", {31'h0, req_ready_o}, 32'h1);

      // SW 0x83828180 @0x20000000
      do_req(1'b1, 3'b010, 32'h2000_0000, 32'h8382_8180, lat, wt);
      chk("sw_lat",   lat, 3);
      chk("sw_err",   {31'h0, rsp_err_o}, 32'h0);
      chk("sw_rdata", rsp_rdata_o, 32'h0);
      chk("sw_sel",   {28'h0, last_sel}, 32'hF);
      chk("sw_dat",   last_dat, 32'h8382_8180);
      chk("sw_we",    {31'h0, last_we}, 32'h1);
      @(negedge clk);
      chk("pulse_one", {31'h0, rsp_valid_o}, 32'h0);

      // LB @0x20000000
      do_req(1'b0, 3'b000, 32'h2000_0000, 32'h0, lat, wt);
      chk("lb_lat",   lat, 3);
      chk("lb_rdata", rsp_rdata_o, 32'hFFFF_FF80);
      chk("lb_sel",   {28'h0, last_sel}, 32'h1);
      chk("lb_adr",   last_adr, 32'h2000_0000);
      chk("lb_we",    {31'h0, last_we}, 32'h0);

      // LHU @0x20000002, issued straight after the previous response
      do_req(1'b0, 3'b101, 32'h2000_0002, 32'h0, lat, wt);
      chk("b2b_wait",  wt, 1);
      chk("lhu_rdata", rsp_rdata_o, 32'h0000_8382);
      chk("lhu_sel",   {28'h0, last_sel}, 32'hC);
      chk("lhu_adr",   last_adr, 32'h2000_0000);

      do_req(1'b0, 3'b001, 32'h2000_0002, 32'h0, lat, wt);
      chk("lh_rdata", rsp_rdata_o, 32'hFFFF_8382);
      do_req(1'b0, 3'b100, 32'h2000_0001, 32'h0, lat, wt);
      chk("lbu_rdata", rsp_rdata_o, 32'h0000_0081);
      chk("lbu_sel",   {28'h0, last_sel}, 32'h2);
      do_req(1'b0, 3'b010, 32'h2000_0000, 32'h0, lat, wt);
      chk("lw_rdata", rsp_rdata_o, 32'h8382_8180);

      // SB onto 0xDEADBEEF
      do_req(1'b1, 3'b010, 32'h2000_0000, 32'hDEAD_BEEF, lat, wt);
      do_req(1'b1, 3'b000, 32'h2000_0003, 32'hF3F2_F1F0, lat, wt);
      chk("sb_sel", {28'h0, last_sel}, 32'h8);
      chk("sb_dat", last_dat, 32'hF0F0_F0F0);
      chk("sb_err", {31'h0, rsp_err_o}, 32'h0);
      do_req(1'b0, 3'b010, 32'h2000_0000, 32'h0, lat, wt);
      chk("sb_mem", rsp_rdata_o, 32'hF0AD_BEEF);

      // SH to upper half
      do_req(1'b1, 3'b001, 32'h2000_0002, 32'h1234_ABCD, lat, wt);
      chk("sh_sel", {28'h0, last_sel}, 32'hC);
      chk("sh_dat", last_dat, 32'hABCD_ABCD);
      do_req(1'b0, 3'b010, 32'h2000_0000, 32'h0, lat, wt);
      chk("sh_mem", rsp_rdata_o, 32'hABCD_BEEF);

      // Illegal funct3: no bus cycle, error in the cycle after accept
      bc0 = bus_cycles;
      do_req(1'b0, 3'b011, 32'h2000_0000, 32'h0, lat, wt);
      chk("ill_ld_lat",   lat, 2);
      chk("ill_ld_err",   {31'h0, rsp_err_o}, 32'h1);
      chk("ill_ld_rdata", rsp_rdata_o, 32'h0);
      do_req(1'b1, 3'b100, 32'h2000_0000, 32'h0, lat, wt);
      chk("ill_st_err", {31'h0, rsp_err_o}, 32'h1);
      repeat (4) @(negedge clk);
      chk("ill_nobus",  bus_cycles - bc0, 0);
      chk("err_hold",   {31'h0, rsp_err_o}, 32'h1);

      // Three retries then ack
      rty_cfg = 3;
      bc0 = bus_cycles;
      bs0 = bus_starts;
      do_req(1'b0, 3'b010, 32'h2000_0000, 32'h0, lat, wt);
      chk("rty3_rdata",  rsp_rdata_o, 32'hABCD_BEEF);
      chk("rty3_err",    {31'h0, rsp_err_o}, 32'h0);
      chk("rty3_starts", bus_starts - bs0, 4);
      chk("rty3_cycles", bus_cycles - bc0, 4);
      chk("rty3_lat",    lat, 9);

      // Four retries exceed the limit
      rty_cfg = 4;
      bs0 = bus_starts;
      do_req(1'b0, 3'b010, 32'h2000_0000, 32'h0, lat, wt);
      chk("rty4_err",    {31'h0, rsp_err_o}, 32'h1);
      chk("rty4_rdata",  rsp_rdata_o, 32'h0);
      chk("rty4_starts", bus_starts - bs0, 4);
      rty_cfg = 0;

      // err_i together with ack_i: error wins
      err_cfg = 1'b1;
      do_req(1'b0, 3'b010, 32'h2000_0000, 32'h0, lat, wt);
      chk("buserr_err",   {31'h0, rsp_err_o}, 32'h1);
      chk("buserr_rdata", rsp_rdata_o, 32'h0);
      err_cfg = 1'b0;

      // Misaligned accesses
      bc0 = bus_cycles;
`ifdef LSU_MISALIGN_TRAP_EN
      do_req(1'b0, 3'b010, 32'h2000_0002, 32'h0, lat, wt);
      chk("mis_lw_err",   {31'h0, rsp_err_o}, 32'h1);
      do_req(1'b0, 3'b001, 32'h2000_0001, 32'h0, lat, wt);
      chk("mis_lh_err",   {31'h0, rsp_err_o}, 32'h1);
      chk("mis_nobus",    bus_cycles - bc0, 0);
`else
      do_req(1'b0, 3'b010, 32'h2000_0002, 32'h0, lat, wt);
      chk("mis_lw_rdata", rsp_rdata_o, 32'hABCD_BEEF);
      chk("mis_lw_err",   {31'h0, rsp_err_o}, 32'h0);
      chk("mis_lw_sel",   {28'h0, last_sel}, 32'hF);
      chk("mis_lw_adr",   last_adr, 32'h2000_0000);
      do_req(1'b0, 3'b001, 32'h2000_0001, 32'h0, lat, wt);
      chk("mis_lh_rdata", rsp_rdata_o, 32'hFFFF_BEEF);
      chk("mis_lh_sel",   {28'h0, last_sel}, 32'h3);
`endif

      // Reset during BUS
      stall_cfg = 1'b1;
      @(negedge clk);
      req_we_i     = 1'b0;
      req_funct3_i = 3'b010;
      req_addr_i   = 32'h2000_0000;
      req_valid_i  = 1'b1;
      @(negedge clk);
      req_valid_i = 1'b0;
      chk("abort_cyc_on", {31'h0, cyc_o}, 32'h1);
      rc0 = rsp_count;
      rst_ni = 1'b0;
      #1;
      chk("abort_cyc_off", {30'h0, cyc_o, stb_o}, 32'h0);
      chk("abort_ready",   {31'h0, req_ready_o}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_ni    = 1'b1;
      stall_cfg = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_no_rsp", rsp_count - rc0, 0);
      chk("abort_state",  {30'h0, state_o}, 32'h0);
      do_req(1'b0, 3'b010, 32'h2000_0000, 32'h0, lat, wt);
      chk("post_rst_lat",   lat, 3);
      chk("post_rst_rdata", rsp_rdata_o, 32'hABCD_BEEF);
      chk("post_rst_err",   {31'h0, rsp_err_o}, 32'h0);
      @(negedge clk);
      chk("post_rst_count", rsp_count - rc0, 1);
      chk("adr_stable",     unstable, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
